video_restart_ctrl: RTL and testbench

Sequences the HDMI frame-output generator (the RAM-to-video hq2x scanout block) across video-mode changes, hq2x toggles and input loss. Holds the generator in reset and waits for the capture side to settle. Then issues a single-cycle start trigger, timed to the input frame start so that read and write pointers stay a fixed number of lines apart. Supervises the running generator and restarts it when the input disappears or output never reaches a full cycle.

---
 rtl/video_ctrl_pkg.sv | 31 +++
 rtl/video_restart_ctrl_if.sv | 29 ++
 rtl/frame_watchdog.sv | 36 +++
 rtl/video_restart_ctrl.sv | 133 +++++++++++++
 tb/tb_video_restart_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_ctrl_pkg.sv
// Shared types and default constants for the video restart sequencer and
// its frame watchdog.
package video_ctrl_pkg;

    typedef enum logic [2:0] {
        HOLD,
        SETTLE,
        ARM,
        WAIT_LINES,
        TRIGGER,
        RUN
    } restart_state_t;

    typedef enum logic [1:0] {
        CAUSE_CFG,
        CAUSE_HQ2X,
        CAUSE_FRAME_TO,
        CAUSE_FULLCYCLE_TO
    } restart_cause_t;

    localparam int DEF_SETTLE_FRAMES    = 2;
    localparam int DEF_TRIGGER_LINES    = 3;
    localparam int DEF_LINE_W           = 12;
    localparam int DEF_TIMEOUT_W        = 24;
    localparam int DEF_FRAME_TIMEOUT    = 2_000_000;
    localparam int DEF_FULLCYCLE_FRAMES = 8;

    // Width of the shared settle / fullcycle frame counter.
    localparam int CNT_W = 8;

endpackage

// File: rtl/video_restart_ctrl_if.sv
// Handshake bundle between the capture side / generator and the restart
// sequencer. master drives the stimulus side, slave is the sequencer.
interface video_restart_ctrl_if
    import video_ctrl_pkg::*;
#(
    parameter int LINE_W = DEF_LINE_W
);
    logic              cfg_changed;
    logic              hq2x_req;
    logic              in_frame_start;
    logic [LINE_W-1:0] in_line_count;
    logic              fullcycle;
    logic              gen_reset;
    logic              starttrigger;
    logic              hq2x;
    logic              running;
    logic [7:0]        restart_count;
    restart_cause_t    last_cause;

    modport master (
        output cfg_changed, hq2x_req, in_frame_start, in_line_count, fullcycle,
        input  gen_reset, starttrigger, hq2x, running, restart_count, last_cause
    );

    modport slave (
        input  cfg_changed, hq2x_req, in_frame_start, in_line_count, fullcycle,
        output gen_reset, starttrigger, hq2x, running, restart_count, last_cause
    );
endinterface

// File: rtl/frame_watchdog.sv
// Clock counter cleared by a frame start; flags an expiry when TIMEOUT clocks
// pass without a clear. Saturates instead of wrapping.
module frame_watchdog #(
    parameter int WIDTH   = 24,
    parameter int TIMEOUT = 2_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(TIMEOUT - 1);

    logic [WIDTH-1:0] count_reg, count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count_reg != '1)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expire = enable && !clear && (count_reg == LAST);

endmodule

// File: rtl/video_restart_ctrl.sv
// Restart sequencer for the hq2x scanout generator: hold, settle on input
// frames, trigger at a fixed line offset, then supervise the running output.
module video_restart_ctrl
    import video_ctrl_pkg::*;
#(
    parameter int SETTLE_FRAMES    = DEF_SETTLE_FRAMES,
    parameter int TRIGGER_LINES    = DEF_TRIGGER_LINES,
    parameter int LINE_W           = DEF_LINE_W,
    parameter int TIMEOUT_W        = DEF_TIMEOUT_W,
    parameter int FRAME_TIMEOUT    = DEF_FRAME_TIMEOUT,
    parameter int FULLCYCLE_FRAMES = DEF_FULLCYCLE_FRAMES
) (
    input  logic               clock,
    input  logic               reset_n,
    video_restart_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_FRAMES - 1);
    localparam logic [CNT_W-1:0]  FC_LAST     = CNT_W'(FULLCYCLE_FRAMES - 1);
    localparam logic [LINE_W-1:0] TRIG_LINE   = LINE_W'(TRIGGER_LINES);

    restart_state_t   state_reg, state_next;
    restart_cause_t   cause_reg, cause_next;
    logic [CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
    logic             fc_seen_reg, fc_seen_next;
    logic             gen_reset_reg, starttrigger_reg, running_reg, hq2x_reg;
    logic [7:0]       restart_count_reg;

    logic wd_clear, wd_enable, wd_expire;
    logic fc_counting, fc_expire, hq2x_mismatch, rst_req;

    assign wd_enable = (state_reg == RUN);
    assign wd_clear  = (state_reg != RUN) || bus.in_frame_start;

    frame_watchdog #(
        .WIDTH   (TIMEOUT_W),
        .TIMEOUT (FRAME_TIMEOUT)
    ) u_frame_watchdog (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expire  (wd_expire)
    );

    // The fullcycle check stops for good once the generator reports one.
    assign fc_counting   = (state_reg == RUN) && !fc_seen_reg && !bus.fullcycle;
    assign fc_expire     = fc_counting && bus.in_frame_start && (frame_cnt_reg == FC_LAST);
    assign hq2x_mismatch = (bus.hq2x_req != hq2x_reg);
    assign rst_req       = (state_reg != HOLD) &&
                           (bus.cfg_changed || hq2x_mismatch || wd_expire || fc_expire);

    always_comb begin
        state_next     = state_reg;
        frame_cnt_next = frame_cnt_reg;
        fc_seen_next   = fc_seen_reg;
        unique case (state_reg)
            HOLD: begin
                frame_cnt_next = '0;
                state_next     = SETTLE;
            end
            SETTLE: begin
                if (bus.in_frame_start) begin
                    frame_cnt_next = frame_cnt_reg + 1'b1;
                    if (frame_cnt_reg == SETTLE_LAST) state_next = ARM;
                end
            end
            ARM: begin
                if (bus.in_frame_start) state_next = WAIT_LINES;
            end
            WAIT_LINES: begin
                // A new frame before the trigger line means the frame was short.
                if (bus.in_frame_start)                 state_next = ARM;
                else if (bus.in_line_count == TRIG_LINE) state_next = TRIGGER;
            end
            TRIGGER: begin
                frame_cnt_next = '0;
                fc_seen_next   = 1'b0;
                state_next     = RUN;
            end
            RUN: begin
                if (bus.fullcycle) fc_seen_next = 1'b1;
                if (fc_counting && bus.in_frame_start) frame_cnt_next = frame_cnt_reg + 1'b1;
            end
            default: state_next = HOLD;
        endcase
        if (rst_req) begin
            state_next     = HOLD;
            frame_cnt_next = '0;
        end
    end

    always_comb begin
        cause_next = cause_reg;
        if (bus.cfg_changed)    cause_next = CAUSE_CFG;
        else if (hq2x_mismatch) cause_next = CAUSE_HQ2X;
        else if (wd_expire)     cause_next = CAUSE_FRAME_TO;
        else if (fc_expire)     cause_next = CAUSE_FULLCYCLE_TO;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= HOLD;
            cause_reg         <= CAUSE_CFG;
            frame_cnt_reg     <= '0;
            fc_seen_reg       <= 1'b0;
            gen_reset_reg     <= 1'b1;
            starttrigger_reg  <= 1'b0;
            running_reg       <= 1'b0;
            hq2x_reg          <= 1'b0;
            restart_count_reg <= '0;
        end else begin
            state_reg        <= state_next;
            frame_cnt_reg    <= frame_cnt_next;
            fc_seen_reg      <= fc_seen_next;
            gen_reset_reg    <= (state_next == HOLD) || (state_next == SETTLE);
            starttrigger_reg <= (state_next == TRIGGER);
            running_reg      <= (state_next == RUN);
            if (state_reg == HOLD) hq2x_reg <= bus.hq2x_req;
            if (rst_req) cause_reg <= cause_next;
            if ((wd_expire || fc_expire) && (restart_count_reg != 8'hFF)) begin
                restart_count_reg <= restart_count_reg + 8'd1;
            end
        end
    end

    assign bus.gen_reset     = gen_reset_reg;
    assign bus.starttrigger  = starttrigger_reg;
    assign bus.running       = running_reg;
    assign bus.hq2x          = hq2x_reg;
    assign bus.restart_count = restart_count_reg;
    assign bus.last_cause    = cause_reg;

endmodule

// File: tb/tb_video_restart_ctrl.sv
// Randomised bench for video_restart_ctrl: a periodic frame source feeds the
// sequencer and expected edges are derived from the recorded frame-start times.
module tb_video_restart_ctrl;
    import video_ctrl_pkg::*;

    localparam int LINE_W     = 12;
    localparam int SETTLE     = 2;
    localparam int TRIG_LINES = 3;
    localparam int FC_FRAMES  = 8;
    localparam int TIMEOUT    = 5000;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    video_restart_ctrl_if #(.LINE_W(LINE_W)) vif ();

    video_restart_ctrl #(
        .SETTLE_FRAMES    (SETTLE),
        .TRIGGER_LINES    (TRIG_LINES),
        .LINE_W           (LINE_W),
        .TIMEOUT_W        (24),
        .FRAME_TIMEOUT    (TIMEOUT),
        .FULLCYCLE_FRAMES (FC_FRAMES)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (vif.slave)
    );

    int tests = 0;
    int fails = 0;

    // Edge counter: value seen at a negedge = number of posedges so far.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Frame source: a frame start every `period` clocks, line count = phase/step.
    int period = 400;
    int step   = 20;
    bit src_en = 1'b0;
    int cfg_req = 0, cfg_ack = 0, cfg_fs_req = 0, cfg_fs_ack = 0;
    int cfg_edge = -1;
    int fs_q[$];
    int phase = 0;

    initial begin
        vif.in_frame_start = 1'b0;
        vif.in_line_count  = '0;
        vif.cfg_changed    = 1'b0;
        forever begin
            @(negedge clock);
            vif.cfg_changed    = 1'b0;
            vif.in_frame_start = 1'b0;
            if (!src_en) begin
                phase = period - 1;
            end else begin
                phase = (phase + 1) % period;
                vif.in_line_count = LINE_W'(phase / step);
                if (phase == 0) begin
                    vif.in_frame_start = 1'b1;
                    fs_q.push_back(cyc + 1);
                    if (cfg_fs_req != cfg_fs_ack) begin
                        cfg_fs_ack      = cfg_fs_req;
                        vif.cfg_changed = 1'b1;
                        cfg_edge        = cyc + 1;
                    end
                end
            end
            if (cfg_req != cfg_ack) begin
                cfg_ack         = cfg_req;
                vif.cfg_changed = 1'b1;
                cfg_edge        = cyc + 1;
            end
        end
    end

    // Output monitor: edges at which starttrigger was high and gen_reset moved.
    int trig_q[$], rise_q[$], fall_q[$];
    logic prev_gr = 1'b1;
    initial begin
        forever begin
            @(negedge clock);
            if (vif.starttrigger === 1'b1) trig_q.push_back(cyc);
            if (vif.gen_reset !== prev_gr) begin
                if (vif.gen_reset === 1'b1) rise_q.push_back(cyc);
                else                        fall_q.push_back(cyc);
            end
            prev_gr = vif.gen_reset;
        end
    end

    function automatic int last_trig();
        return (trig_q.size() > 0) ? trig_q[trig_q.size()-1] : -1;
    endfunction
    function automatic int last_rise();
        return (rise_q.size() > 0) ? rise_q[rise_q.size()-1] : -1;
    endfunction
    function automatic int last_fall();
        return (fall_q.size() > 0) ? fall_q[fall_q.size()-1] : -1;
    endfunction

    function automatic int nth_fs_from(input int e, input int n);
        int k = 0;
        foreach (fs_q[i]) begin
            if (fs_q[i] >= e) begin
                k++;
                if (k == n) return fs_q[i];
            end
        end
        return -1;
    endfunction

    function automatic int count_fs_from(input int e);
        int k = 0;
        foreach (fs_q[i]) if (fs_q[i] >= e) k++;
        return k;
    endfunction

    // Reference model of a re-arm after the generator was put in reset at edge r:
    // the first frame starts sampled in settle are from edge r+2; the 2nd releases
    // reset, the next frame arms, and the trigger lands TRIG_LINES*step into it.
    function automatic void rearm_model(input int r, output int g, output int t);
        int w;
        g = nth_fs_from(r + 2, SETTLE);
        w = (g < 0) ? -1 : nth_fs_from(g + 1, 1);
        t = (w < 0) ? -1 : w + TRIG_LINES * step;
    endfunction

    task automatic wait_trig(input int n0, input string name, output bit ok);
        for (int i = 0; i < 20000 && trig_q.size() <= n0; i++) @(negedge clock);
        ok = (trig_q.size() > n0);
        if (!ok) begin
            tests++; fails++;
            $display("FAIL %s_trigger_timeout: got no starttrigger, want one within 20000 clocks", name);
        end
    endtask

    task automatic wait_rise(input int n0, input int bound, input string name, output bit ok);
        for (int i = 0; i < bound && rise_q.size() <= n0; i++) @(negedge clock);
        ok = (rise_q.size() > n0);
        if (!ok) begin
            tests++; fails++;
            $display("FAIL %s_restart_timeout: got no gen_reset rise, want one within %0d clocks", name, bound);
        end
    endtask

    task automatic test_reset();
        vif.hq2x_req  = 1'b0;
        vif.fullcycle = 1'b1;
        reset_n       = 1'b0;
        repeat (3) @(negedge clock);
        tests++; if (vif.gen_reset !== 1'b1) begin fails++; $display("FAIL reset_gen_reset: got %b want 1", vif.gen_reset); end
        tests++; if (vif.starttrigger !== 1'b0) begin fails++; $display("FAIL reset_starttrigger: got %b want 0", vif.starttrigger); end
        tests++; if (vif.hq2x !== 1'b0) begin fails++; $display("FAIL reset_hq2x: got %b want 0", vif.hq2x); end
        tests++; if (vif.running !== 1'b0) begin fails++; $display("FAIL reset_running: got %b want 0", vif.running); end
        tests++; if (vif.restart_count !== 8'd0) begin fails++; $display("FAIL reset_restart_count: got %0d want 0", vif.restart_count); end
        $display("[TB] reset: outputs sampled in reset");
    endtask

    task automatic test_startup();
        int r, g, t, n0;
        bit ok;
        period = int'($urandom_range(500, 200));
        step   = int'($urandom_range(period / 6, 10));
        src_en = 1'b1;
        repeat (int'($urandom_range(60, 1))) @(negedge clock);
        n0 = trig_q.size();
        r  = cyc;
        reset_n = 1'b1;
        wait_trig(n0, "startup", ok);
        if (ok) begin
            rearm_model(r, g, t);
            tests++; if (last_fall() != g) begin fails++; $display("FAIL startup_reset_release: got edge %0d want %0d", last_fall(), g); end
            tests++; if (last_trig() != t) begin fails++; $display("FAIL startup_trigger_edge: got edge %0d want %0d", last_trig(), t); end
            repeat (2 * period) @(negedge clock);
            tests++; if (trig_q.size() != n0 + 1) begin fails++; $display("FAIL startup_trigger_count: got %0d want %0d", trig_q.size() - n0, 1); end
            tests++; if (vif.running !== 1'b1) begin fails++; $display("FAIL startup_running: got %b want 1", vif.running); end
            tests++; if (vif.gen_reset !== 1'b0) begin fails++; $display("FAIL startup_gen_reset: got %b want 0", vif.gen_reset); end
        end
        $display("[TB] startup: period %0d step %0d trigger at edge %0d", period, step, last_trig());
    endtask

    task automatic test_hq2x_toggle();
        int c, g, t, n0;
        bit ok;
        repeat (int'($urandom_range(period, 1))) @(negedge clock);
        n0 = trig_q.size();
        c  = cyc;
        vif.hq2x_req = 1'b1;
        @(negedge clock);
        tests++; if (vif.gen_reset !== 1'b1) begin fails++; $display("FAIL hq2x_gen_reset_latency: got %b want 1", vif.gen_reset); end
        @(negedge clock);
        tests++; if (vif.hq2x !== 1'b1 || vif.gen_reset !== 1'b1) begin fails++; $display("FAIL hq2x_under_reset: got hq2x=%b gen_reset=%b want 1/1", vif.hq2x, vif.gen_reset); end
        tests++; if (last_rise() != c + 1) begin fails++; $display("FAIL hq2x_rise_edge: got %0d want %0d", last_rise(), c + 1); end
        tests++; if (vif.last_cause !== CAUSE_HQ2X) begin fails++; $display("FAIL hq2x_cause: got %0d want %0d", int'(vif.last_cause), int'(CAUSE_HQ2X)); end
        wait_trig(n0, "hq2x", ok);
        if (ok) begin
            rearm_model(c + 1, g, t);
            tests++; if (last_fall() != g) begin fails++; $display("FAIL hq2x_reset_release: got edge %0d want %0d", last_fall(), g); end
            tests++; if (last_trig() != t) begin fails++; $display("FAIL hq2x_trigger_edge: got edge %0d want %0d", last_trig(), t); end
            repeat (2 * period) @(negedge clock);
            tests++; if (trig_q.size() != n0 + 1) begin fails++; $display("FAIL hq2x_trigger_count: got %0d want 1", trig_q.size() - n0); end
            tests++; if (vif.restart_count !== 8'd0) begin fails++; $display("FAIL hq2x_restart_count: got %0d want 0", vif.restart_count); end
        end
        $display("[TB] hq2x toggle: restart at edge %0d, re-trigger at edge %0d", c + 1, last_trig());
    endtask

    task automatic test_frame_timeout();
        int l, g, t, n0, nr, exp_rise;
        bit ok;
        n0 = trig_q.size();
        nr = rise_q.size();
        src_en = 1'b0;
        @(negedge clock);
        l = fs_q[fs_q.size()-1];
        exp_rise = l + TIMEOUT;
        wait_rise(nr, TIMEOUT + 100, "frame_timeout", ok);
        if (ok) begin
            tests++; if (last_rise() != exp_rise) begin fails++; $display("FAIL frame_timeout_edge: got edge %0d want %0d", last_rise(), exp_rise); end
            @(negedge clock);
            tests++; if (vif.restart_count !== 8'd1) begin fails++; $display("FAIL frame_timeout_count: got %0d want 1", vif.restart_count); end
            tests++; if (vif.last_cause !== CAUSE_FRAME_TO) begin fails++; $display("FAIL frame_timeout_cause: got %0d want %0d", int'(vif.last_cause), int'(CAUSE_FRAME_TO)); end
            repeat (int'($urandom_range(300, 5))) @(negedge clock);
            src_en = 1'b1;
            wait_trig(n0, "frame_timeout", ok);
            if (ok) begin
                rearm_model(exp_rise, g, t);
                tests++; if (last_trig() != t) begin fails++; $display("FAIL frame_timeout_retrigger: got edge %0d want %0d", last_trig(), t); end
            end
        end
        src_en = 1'b1;
        $display("[TB] frame timeout: last frame %0d, restart at edge %0d", l, last_rise());
    endtask

    task automatic test_async_reset();
        int r, g, t, n0;
        bit ok;
        repeat (period + int'($urandom_range(period, 1))) @(negedge clock);
        vif.fullcycle = 1'b0;
        n0 = trig_q.size();
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        tests++; if (vif.gen_reset !== 1'b1) begin fails++; $display("FAIL async_reset_gen_reset: got %b want 1", vif.gen_reset); end
        tests++; if (vif.running !== 1'b0) begin fails++; $display("FAIL async_reset_running: got %b want 0", vif.running); end
        tests++; if (vif.restart_count !== 8'd0) begin fails++; $display("FAIL async_reset_count: got %0d want 0", vif.restart_count); end
        @(negedge clock);
        r = cyc;
        reset_n = 1'b1;
        tests++; if (trig_q.size() != n0) begin fails++; $display("FAIL async_reset_no_trigger: got %0d pulses want 0", trig_q.size() - n0); end
        wait_trig(n0, "async_reset", ok);
        if (ok) begin
            rearm_model(r, g, t);
            tests++; if (last_trig() != t) begin fails++; $display("FAIL async_reset_retrigger: got edge %0d want %0d", last_trig(), t); end
        end
        $display("[TB] async reset: released at edge %0d, trigger at edge %0d", r, last_trig());
    endtask

    task automatic test_fullcycle();
        int t1, t2, e8, g, t, n0, nr;
        bit ok;
        t1 = last_trig();
        n0 = trig_q.size();
        nr = rise_q.size();
        wait_rise(nr, (FC_FRAMES + 2) * period + 100, "fullcycle", ok);
        if (ok) begin
            e8 = nth_fs_from(t1 + 1, FC_FRAMES);
            tests++; if (last_rise() != e8) begin fails++; $display("FAIL fullcycle_restart_edge: got edge %0d want %0d", last_rise(), e8); end
            @(negedge clock);
            tests++; if (vif.restart_count !== 8'd1) begin fails++; $display("FAIL fullcycle_count: got %0d want 1", vif.restart_count); end
            tests++; if (vif.last_cause !== CAUSE_FULLCYCLE_TO) begin fails++; $display("FAIL fullcycle_cause: got %0d want %0d", int'(vif.last_cause), int'(CAUSE_FULLCYCLE_TO)); end
            wait_trig(n0, "fullcycle", ok);
            if (ok) begin
                rearm_model(e8, g, t);
                tests++; if (last_trig() != t) begin fails++; $display("FAIL fullcycle_retrigger: got edge %0d want %0d", last_trig(), t); end
                t2 = last_trig();
                for (int i = 0; i < 4 * period && count_fs_from(t2 + 1) < 3; i++) @(negedge clock);
                vif.fullcycle = 1'b1;
                nr = rise_q.size();
                repeat ((FC_FRAMES + 4) * period) @(negedge clock);
                tests++; if (rise_q.size() != nr) begin fails++; $display("FAIL fullcycle_seen_no_restart: got %0d restarts want 0", rise_q.size() - nr); end
                tests++; if (vif.restart_count !== 8'd1) begin fails++; $display("FAIL fullcycle_seen_count: got %0d want 1", vif.restart_count); end
                tests++; if (vif.running !== 1'b1) begin fails++; $display("FAIL fullcycle_seen_running: got %b want 1", vif.running); end
            end
        end
        $display("[TB] fullcycle: restart at edge %0d, count %0d", last_rise(), vif.restart_count);
    endtask

    task automatic test_settle_collision();
        int r, c, g, t, n0, nr, nf;
        bit ok;
        repeat (int'($urandom_range(period, 1))) @(negedge clock);
        n0 = trig_q.size();
        nr = rise_q.size();
        nf = fall_q.size();
        cfg_req++;
        wait_rise(nr, 10, "collision", ok);
        if (ok) begin
            r = cfg_edge;
            tests++; if (last_rise() != r) begin fails++; $display("FAIL collision_cfg_latency: got edge %0d want %0d", last_rise(), r); end
            for (int i = 0; i < 3 * period && count_fs_from(r + 2) < 1; i++) @(negedge clock);
            cfg_fs_req++;
            for (int i = 0; i < 3 * period && cfg_fs_ack != cfg_fs_req; i++) @(negedge clock);
            c = cfg_edge;
            wait_trig(n0, "collision", ok);
            if (ok) begin
                rearm_model(c, g, t);
                tests++; if (fall_q.size() != nf + 1) begin fails++; $display("FAIL collision_release_count: got %0d want 1", fall_q.size() - nf); end
                tests++; if (last_fall() != g) begin fails++; $display("FAIL collision_reset_release: got edge %0d want %0d", last_fall(), g); end
                tests++; if (last_trig() != t) begin fails++; $display("FAIL collision_trigger_edge: got edge %0d want %0d", last_trig(), t); end
            end
        end
        $display("[TB] settle collision: cfg at frame edge %0d, trigger at edge %0d", c, last_trig());
    endtask

    initial begin
        test_reset();
        test_startup();
        test_hq2x_toggle();
        test_frame_timeout();
        test_async_reset();
        test_fullcycle();
        test_settle_collision();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #(10 * 95_000);
        $display("FAIL global_timeout: got no completion, want finish within 95000 clocks");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
